// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package multdiv_pkg;

  localparam int ITERS = 32;

  // Most negative 32-bit value; the only dividend that can overflow.
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/multdiv_unit_addsub33.sv
// 33-bit adder/subtractor shared by Booth steps, trial subtracts and negations.
module addsub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit.
// The start cycle negates a negative dividend, 32 iteration cycles follow,
// and one wrap-up cycle fixes the quotient sign and loads the outputs.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = multdiv_pkg::ITERS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(ITERS);

  state_t state, next_state;

  logic [CW-1:0]  counter;
  logic           wrap_up;
  logic           neg_q;
  logic           div_zero;
  logic           div_ovf;
  logic           qm1;
  logic [WIDTH:0] acc;
  logic [WIDTH:0] mcand;
  logic [WIDTH-1:0] mplier;

  logic [WIDTH:0] add_a;
  logic [WIDTH:0] add_b;
  logic [WIDTH:0] sum;
  logic           add_sub;

  logic           start;
  logic [WIDTH:0] acc_shl;
  logic           mul_ovf;
  logic [WIDTH-1:0] a_mag;

  assign start = ctrl_MULT | ctrl_DIV;

  // Divide: partial remainder shifted left with the next dividend bit.
  // Multiply: product bits [63:31], which must be uniform to fit in 32 bits.
  assign acc_shl = {acc[WIDTH-1:0], mplier[WIDTH-1]};
  assign mul_ovf = (|acc_shl) & ~(&acc_shl);

  // On a start edge the adder computes 0 - A, giving the dividend magnitude.
  assign a_mag = data_operandA[WIDTH-1] ? sum[WIDTH-1:0] : data_operandA;

  addsub33 u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (sum)
  );

  // Steer the shared adder according to what this cycle needs.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    if (start) begin
      add_b   = {data_operandA[WIDTH-1], data_operandA};
      add_sub = 1'b1;
    end else if (state == MULT && !wrap_up) begin
      add_a   = acc;
      add_b   = (mplier[0] ^ qm1) ? mcand : '0;
      add_sub = mplier[0] & ~qm1;
    end else if (state == DIV) begin
      if (!wrap_up) begin
        // Subtracting |B| is the same as adding B when B is negative.
        add_a   = acc_shl;
        add_b   = mcand;
        add_sub = ~mcand[WIDTH];
      end else begin
        add_b   = {1'b0, mplier};
        add_sub = neg_q;
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a start always wins and restarts the unit.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = ctrl_MULT ? MULT : DIV;
    end else begin
      case (state)
        MULT, DIV: if (wrap_up) next_state = DONE;
        DONE:      next_state = IDLE;
        default:   next_state = state;
      endcase
    end
  end

  // Operand latching, iteration datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter        <= '0;
      wrap_up        <= 1'b0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      qm1            <= 1'b0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        acc      <= '0;
        qm1      <= 1'b0;
        counter  <= '0;
        wrap_up  <= 1'b0;
        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == INT_MIN) && (&data_operandB);
        if (ctrl_MULT) begin
          mcand  <= {data_operandA[WIDTH-1], data_operandA};
          mplier <= data_operandB;
        end else begin
          mcand  <= {data_operandB[WIDTH-1], data_operandB};
          mplier <= a_mag;
        end
      end else if ((state == MULT || state == DIV) && !wrap_up) begin
        counter <= counter + 1'b1;
        wrap_up <= (counter == CW'(ITERS - 1));
        if (state == MULT) begin
          acc    <= {sum[WIDTH], sum[WIDTH:1]};
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          qm1    <= mplier[0];
        end else if (!sum[WIDTH]) begin
          acc    <= sum;
          mplier <= {mplier[WIDTH-2:0], 1'b1};
        end else begin
          acc    <= acc_shl;
          mplier <= {mplier[WIDTH-2:0], 1'b0};
        end
      end else if ((state == MULT || state == DIV) && wrap_up) begin
        wrap_up        <= 1'b0;
        data_resultRDY <= 1'b1;
        if (state == MULT) begin
          data_result    <= mplier;
          data_exception <= mul_ovf;
        end else if (div_zero) begin
          data_result    <= '0;
          data_exception <= 1'b1;
        end else begin
          data_result    <= sum[WIDTH-1:0];
          data_exception <= div_ovf;
        end
      end
    end
  end

endmodule
